// File: rtl/dromajo_ram_ctrl.sv
// Request/response front-end for a 64-bit single-port RAM with optional zero-fill sweep.
// Define DROMAJO_RAM_CTRL_INIT_EN to zero the whole RAM after every reset before accepting requests.
module dromajo_ram_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_DEPTH = 1024,
    parameter int OUT_REGS   = 0
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  ReqValid_SI,
    output logic                  ReqReady_SO,
    input  logic                  ReqWrEn_SI,
    input  logic [7:0]            ReqBEn_SI,
    input  logic [63:0]           ReqWrData_DI,
    input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
    output logic                  RspValid_SO,
    input  logic                  RspReady_SI,
    output logic [63:0]           RspData_DO,
    output logic                  RamCSel_SO,
    output logic                  RamWrEn_SO,
    output logic [7:0]            RamBEn_SO,
    output logic [63:0]           RamWrData_DO,
    output logic [ADDR_WIDTH-1:0] RamAddr_DO,
    input  logic [63:0]           RamRdData_DI,
    output logic                  InitDone_SO
);

    localparam int L  = 1 + OUT_REGS;
    localparam int D  = L + 1;
    localparam int PW = $clog2(D);
    localparam int CW = $clog2(D + 1);
`ifdef DROMAJO_RAM_CTRL_INIT_EN
    localparam logic INIT_EN = 1'b1;
`else
    localparam logic INIT_EN = 1'b0;
`endif

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_init_addr;
    logic                  r_init_done;
    logic [L-1:0]          r_vld_pipe;
    logic [63:0]           r_fifo [D];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_cnt;

    logic          w_run;
    logic [CW-1:0] w_inflight;
    logic          w_rd_room;
    logic          w_ready;
    logic          w_rd_fire;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < L; i++)
            w_inflight = w_inflight + CW'(r_vld_pipe[i]);
    end

    // Reads only enter when every in-flight read already owns a FIFO slot,
    // so a maturing read can never find the FIFO full.
    assign w_run     = (r_state == S_RUN);
    assign w_rd_room = ((CW+1)'(w_inflight) + (CW+1)'(r_cnt)) < (CW+1)'(D);
    assign w_ready   = w_run & (ReqWrEn_SI | w_rd_room);
    assign w_rd_fire = ReqValid_SI & w_ready & ~ReqWrEn_SI;
    assign w_push    = r_vld_pipe[L-1];
    assign w_pop     = (r_cnt != '0) & RspReady_SI;

    assign ReqReady_SO  = Rst_RBI & w_ready;
    assign RamCSel_SO   = Rst_RBI & (w_run ? (ReqValid_SI & w_ready) : 1'b1);
    assign RamWrEn_SO   = Rst_RBI & (w_run ? ReqWrEn_SI : 1'b1);
    assign RamBEn_SO    = !Rst_RBI ? 8'h00 : (w_run ? ReqBEn_SI : 8'hFF);
    assign RamWrData_DO = (Rst_RBI && w_run) ? ReqWrData_DI : 64'h0;
    assign RamAddr_DO   = !Rst_RBI ? '0 : (w_run ? ReqAddr_DI : r_init_addr);
    assign RspValid_SO  = Rst_RBI & (r_cnt != '0);
    assign RspData_DO   = Rst_RBI ? r_fifo[r_rd_ptr] : 64'h0;
    assign InitDone_SO  = Rst_RBI & r_init_done;

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_state     <= INIT_EN ? S_INIT : S_RUN;
            r_init_done <= ~INIT_EN;
            r_init_addr <= '0;
            r_vld_pipe  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            for (int i = 0; i < D; i++)
                r_fifo[i] <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_init_addr == ADDR_WIDTH'(DATA_DEPTH - 1)) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_init_addr <= r_init_addr + 1'b1;
                    end
                end
                default: r_state <= S_RUN;
            endcase

            r_vld_pipe[0] <= w_rd_fire;
            for (int i = 1; i < L; i++)
                r_vld_pipe[i] <= r_vld_pipe[i-1];

            if (w_push) begin
                r_fifo[r_wr_ptr] <= RamRdData_DI;
                r_wr_ptr         <= f_inc(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= f_inc(r_rd_ptr);
            if (w_push && !w_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop)
                r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_dromajo_ram_ctrl.sv
// Random + directed bench for dromajo_ram_ctrl against a transaction-level model
// (reference memory, queue of pending reads with due cycles, queue of ready responses).
module tb_dromajo_ram_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int OR    = 1;
    localparam int L     = OR + 1;
    localparam int D     = L + 1;
`ifdef DROMAJO_RAM_CTRL_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_v, req_rdy, req_we, rsp_v, rsp_rdy;
    logic [7:0]    req_ben, ram_ben;
    logic [63:0]   req_wd, rsp_d, ram_wd, ram_rd;
    logic [AW-1:0] req_a, ram_a;
    logic          ram_cs, ram_we, init_done;

    always #5 clk = ~clk;

    dromajo_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .OUT_REGS(OR)) dut (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .ReqValid_SI(req_v), .ReqReady_SO(req_rdy), .ReqWrEn_SI(req_we),
        .ReqBEn_SI(req_ben), .ReqWrData_DI(req_wd), .ReqAddr_DI(req_a),
        .RspValid_SO(rsp_v), .RspReady_SI(rsp_rdy), .RspData_DO(rsp_d),
        .RamCSel_SO(ram_cs), .RamWrEn_SO(ram_we), .RamBEn_SO(ram_ben),
        .RamWrData_DO(ram_wd), .RamAddr_DO(ram_a), .RamRdData_DI(ram_rd),
        .InitDone_SO(init_done)
    );

    function automatic logic [63:0] pat(input int i);
        return {32'(i) * 32'h9E3779B9, ~32'(i)};
    endfunction

    // Environment RAM: byte-masked writes, L-cycle read latency.
    logic        preload;
    logic [63:0] ram [DEPTH];
    logic [63:0] rd_pipe [L];
    always_ff @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
        end else if (ram_cs && ram_we) begin
            for (int b = 0; b < 8; b++)
                if (ram_ben[b]) ram[ram_a][b*8 +: 8] <= ram_wd[b*8 +: 8];
        end
        rd_pipe[0] <= ram[ram_a];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rd = rd_pipe[L-1];

    // Reference model
    logic [63:0] m_ref [DEPTH];
    logic [63:0] m_fifo [$];
    logic [63:0] m_pend_d [$];
    int          m_pend_t [$];
    bit          m_run;
    int          m_iaddr;
    int          cyc;

    int n_chk = 0, n_err = 0;
    bit s_rdy, s_done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit wr, input logic [7:0] ben,
                        input logic [63:0] wd, input logic [AW-1:0] a, input bit rr);
        bit er;
        rst_n = rst; req_v = v; req_we = wr; req_ben = ben; req_wd = wd; req_a = a; rsp_rdy = rr;
        #1;
        er = rst && m_run && (wr || (m_pend_d.size() + m_fifo.size()) < D);
        s_rdy = req_rdy; s_done = init_done;
        if (!rst) begin
            chk("rst_rdy", req_rdy, 0);  chk("rst_rspv", rsp_v, 0);  chk("rst_rspd", rsp_d, 0);
            chk("rst_cs", ram_cs, 0);    chk("rst_we", ram_we, 0);   chk("rst_ben", ram_ben, 0);
            chk("rst_wd", ram_wd, 0);    chk("rst_a", ram_a, 0);     chk("rst_done", init_done, 0);
        end else begin
            chk("ready", req_rdy, er);
            chk("init_done", init_done, m_run);
            chk("rsp_valid", rsp_v, m_fifo.size() > 0);
            if (m_fifo.size() > 0) chk("rsp_data", rsp_d, m_fifo[0]);
            if (!m_run) begin
                chk("init_cs", ram_cs, 1);  chk("init_we", ram_we, 1);  chk("init_ben", ram_ben, 8'hFF);
                chk("init_wd", ram_wd, 0);  chk("init_a", ram_a, 64'(m_iaddr));
            end else begin
                chk("ram_cs", ram_cs, v && er);
                if (v && er) begin
                    chk("ram_we", ram_we, wr);
                    chk("ram_a", ram_a, a);
                    if (wr) begin chk("ram_ben", ram_ben, ben); chk("ram_wd", ram_wd, wd); end
                end
            end
        end
        @(posedge clk);
        cyc++;
        if (!rst) begin
            m_run = !INIT_EN; m_iaddr = 0;
            m_fifo.delete(); m_pend_d.delete(); m_pend_t.delete();
            if (INIT_EN) for (int i = 0; i < DEPTH; i++) m_ref[i] = '0;
        end else if (!m_run) begin
            if (m_iaddr == DEPTH - 1) m_run = 1; else m_iaddr++;
        end else begin
            if (m_fifo.size() > 0 && rr) void'(m_fifo.pop_front());
            while (m_pend_t.size() > 0 && m_pend_t[0] == cyc) begin
                m_fifo.push_back(m_pend_d.pop_front());
                void'(m_pend_t.pop_front());
            end
            if (v && er) begin
                if (wr) begin
                    for (int b = 0; b < 8; b++)
                        if (ben[b]) m_ref[a][b*8 +: 8] = wd[b*8 +: 8];
                end else begin
                    m_pend_d.push_back(m_ref[a]);
                    m_pend_t.push_back(cyc + L);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic rnd_step(input bit rr);
        step(1, ($urandom % 4) != 0, $urandom % 2, 8'($urandom), {$urandom, $urandom},
             AW'($urandom % 16), rr);
    endtask

    task automatic drain();
        repeat (8) step(1, 0, 0, 0, 0, 0, 1);
    endtask

    // Release reset and count cycles until InitDone rises.
    task automatic wait_init();
        int n = 0;
        int k = 0;
        bit ok = 0;
        while (k < DEPTH + 20) begin
            rnd_step(1);
            k++;
            if (s_done) begin ok = 1; break; end
            n++;
        end
        chk("init_seen", ok, 1);
        chk("init_len", n, INIT_EN ? DEPTH : 0);
    endtask

    task automatic read_wait(input logic [AW-1:0] a, input logic [63:0] exp, input string tag);
        int n = 0;
        step(1, 1, 0, 0, 0, a, 0);
        while (!rsp_v && n < 20) begin step(1, 0, 0, 0, 0, 0, 0); n++; end
        chk({tag, "_lat"}, n, L);
        chk({tag, "_data"}, rsp_d, exp);
        step(1, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int n;
        cyc = 0; m_run = 0; m_iaddr = 0;
        for (int i = 0; i < DEPTH; i++) m_ref[i] = pat(i);
        rst_n = 0; req_v = 0; req_we = 0; req_ben = 0; req_wd = 0; req_a = 0; rsp_rdy = 0;
        preload = 1;
        @(negedge clk);
        step(0, 1, 1, 8'hFF, 64'h1, 3, 1);
        preload = 0;
        step(0, 1, 0, 8'hFF, 64'h2, 4, 1);
        wait_init();

        drain();
        step(1, 1, 1, 8'hFF, 64'hDEADBEEF_CAFEF00D, 5, 1);
        read_wait(5, 64'hDEADBEEF_CAFEF00D, "wr5");
        step(1, 1, 1, 8'hFF, 64'hAAAAAAAA_BBBBBBBB, 7, 1);
        step(1, 1, 1, 8'h0F, 64'h11111111_22222222, 7, 1);
        read_wait(7, 64'hAAAAAAAA_22222222, "ben7");

        // Back-pressure: only D reads fit while the consumer stalls.
        drain();
        n = 0;
        repeat (5) begin step(1, 1, 0, 0, 0, AW'($urandom % 16), 0); n += int'(s_rdy); end
        chk("acc_reads", n, D);
        step(1, 1, 1, 8'hFF, {$urandom, $urandom}, 9, 0);
        chk("wr_when_full", s_rdy, 1);
        repeat (3) step(1, 1, 0, 0, 0, AW'($urandom % 16), 0);
        repeat (10) step(1, 1, 0, 0, 0, AW'($urandom % 16), 1);
        repeat (300) rnd_step(($urandom % 3) != 0);

        // Reset with reads in flight.
        drain();
        step(1, 1, 0, 0, 0, 5, 0);
        step(1, 1, 0, 0, 0, 7, 0);
        step(0, 1, 0, 0, 0, 7, 1);
        wait_init();
        drain();
        repeat (400) rnd_step(($urandom % 4) != 0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
